// File: rtl/qu_common.sv
// Shared queue/scheduler types: station depth, entry address and producer tag.
package qu_common;

    localparam int RES_ST_DEPTH = 32;
    localparam int TAG_W        = 6;

    typedef logic [$clog2(RES_ST_DEPTH)-1:0] res_st_addr_t;
    typedef logic [TAG_W-1:0]                rob_tag_t;

endpackage

// File: rtl/res_st_sched_if.sv
// Dispatch / CDB / issue / flush bundle of the reservation-station scheduler.
interface res_st_sched_if #(
    parameter int RES_ST_DEPTH = qu_common::RES_ST_DEPTH,
    parameter int TAG_W        = qu_common::TAG_W
);
    localparam int AW = $clog2(RES_ST_DEPTH);
    localparam int CW = $clog2(RES_ST_DEPTH + 1);

    logic             alloc_valid;
    logic             alloc_ready;
    logic             alloc_src1_rdy;
    logic             alloc_src2_rdy;
    logic [TAG_W-1:0] alloc_src1_tag;
    logic [TAG_W-1:0] alloc_src2_tag;
    logic             res_st_wr_en;
    logic [AW-1:0]    res_st_wr_addr;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             issue_valid;
    logic [AW-1:0]    issue_addr;
    logic             issue_ready;
    logic             flush;
    logic [CW-1:0]    free_count;

    modport master (
        output alloc_valid, alloc_src1_rdy, alloc_src2_rdy, alloc_src1_tag, alloc_src2_tag,
        output cdb_valid, cdb_tag, issue_ready, flush,
        input  alloc_ready, res_st_wr_en, res_st_wr_addr, issue_valid, issue_addr, free_count
    );

    modport slave (
        input  alloc_valid, alloc_src1_rdy, alloc_src2_rdy, alloc_src1_tag, alloc_src2_tag,
        input  cdb_valid, cdb_tag, issue_ready, flush,
        output alloc_ready, res_st_wr_en, res_st_wr_addr, issue_valid, issue_addr, free_count
    );

endinterface

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder with found flag.
// Latency: combinational. Backpressure: none.
module prio_enc #(
    parameter int N = 32
) (
    input  logic [N-1:0]         req_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = i[$clog2(N)-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/res_st_sched.sv
// Reservation-station scheduler: tracks operand readiness, picks free and issuable entries.
// Latency: alloc/wakeup visible to issue select one cycle later; select outputs combinational.
// Backpressure: alloc_ready drops when full or flushing; an offered entry waits on issue_ready.
module res_st_sched #(
    parameter int RES_ST_DEPTH = qu_common::RES_ST_DEPTH,
    parameter int TAG_W        = qu_common::TAG_W
) (
    input  logic          clk,
    input  logic          rst,
    res_st_sched_if.slave bus
);

    localparam int AW = $clog2(RES_ST_DEPTH);
    localparam int CW = $clog2(RES_ST_DEPTH + 1);

    logic [RES_ST_DEPTH-1:0] valid_q,  valid_d;
    logic [RES_ST_DEPTH-1:0] s1_rdy_q, s1_rdy_d;
    logic [RES_ST_DEPTH-1:0] s2_rdy_q, s2_rdy_d;
    logic [TAG_W-1:0]        s1_tag_q [RES_ST_DEPTH];
    logic [TAG_W-1:0]        s1_tag_d [RES_ST_DEPTH];
    logic [TAG_W-1:0]        s2_tag_q [RES_ST_DEPTH];
    logic [TAG_W-1:0]        s2_tag_d [RES_ST_DEPTH];

    logic [RES_ST_DEPTH-1:0] ready_vec;
    logic [AW-1:0]           free_idx, iss_idx;
    logic                    free_found, iss_found;
    logic                    alloc_fire, issue_fire;
    logic                    byp1, byp2;
    logic [CW-1:0]           used_cnt;

    assign ready_vec = valid_q & s1_rdy_q & s2_rdy_q;

    prio_enc #(.N(RES_ST_DEPTH)) u_free_sel (
        .req_i   (~valid_q),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    prio_enc #(.N(RES_ST_DEPTH)) u_issue_sel (
        .req_i   (ready_vec),
        .idx_o   (iss_idx),
        .found_o (iss_found)
    );

    // Next-state fire strobes stay free of rst; outputs below are gated separately.
    assign alloc_fire = bus.alloc_valid & free_found & ~bus.flush;
    assign issue_fire = bus.issue_ready & iss_found & ~bus.flush;

    assign bus.alloc_ready    = rst & free_found & ~bus.flush;
    assign bus.res_st_wr_en   = rst & alloc_fire;
    assign bus.res_st_wr_addr = free_idx;
    assign bus.issue_valid    = rst & iss_found & ~bus.flush;
    assign bus.issue_addr     = iss_idx;

    always_comb begin
        used_cnt = '0;
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            used_cnt = used_cnt + CW'(valid_q[i]);
        end
    end

    assign bus.free_count = CW'(RES_ST_DEPTH) - used_cnt;

    assign byp1 = bus.cdb_valid & (bus.cdb_tag == bus.alloc_src1_tag);
    assign byp2 = bus.cdb_valid & (bus.cdb_tag == bus.alloc_src2_tag);

    always_comb begin
        valid_d  = valid_q;
        s1_rdy_d = s1_rdy_q;
        s2_rdy_d = s2_rdy_q;
        s1_tag_d = s1_tag_q;
        s2_tag_d = s2_tag_q;
        if (bus.flush) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < RES_ST_DEPTH; i++) begin
                if (valid_q[i] && bus.cdb_valid) begin
                    if (!s1_rdy_q[i] && s1_tag_q[i] == bus.cdb_tag) s1_rdy_d[i] = 1'b1;
                    if (!s2_rdy_q[i] && s2_tag_q[i] == bus.cdb_tag) s2_rdy_d[i] = 1'b1;
                end
            end
            // Alloc targets a free entry and issue a valid one, so they never collide.
            if (issue_fire) valid_d[iss_idx] = 1'b0;
            if (alloc_fire) begin
                valid_d[free_idx]  = 1'b1;
                s1_rdy_d[free_idx] = bus.alloc_src1_rdy | byp1;
                s2_rdy_d[free_idx] = bus.alloc_src2_rdy | byp2;
                s1_tag_d[free_idx] = bus.alloc_src1_tag;
                s2_tag_d[free_idx] = bus.alloc_src2_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            for (int i = 0; i < RES_ST_DEPTH; i++) begin
                s1_tag_q[i] <= '0;
                s2_tag_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            s1_rdy_q <= s1_rdy_d;
            s2_rdy_q <= s2_rdy_d;
            for (int i = 0; i < RES_ST_DEPTH; i++) begin
                s1_tag_q[i] <= s1_tag_d[i];
                s2_tag_q[i] <= s2_tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_res_st_sched.sv
// Bench for res_st_sched: scoreboard of expected write and issue addresses.
module tb_res_st_sched;
    import qu_common::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   wr_q[$];
    int   iss_q[$];

    res_st_sched_if #(.RES_ST_DEPTH(32), .TAG_W(6)) bus ();

    res_st_sched #(.RES_ST_DEPTH(32), .TAG_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.alloc_valid    = 1'b0;
        bus.alloc_src1_rdy = 1'b0;
        bus.alloc_src2_rdy = 1'b0;
        bus.alloc_src1_tag = '0;
        bus.alloc_src2_tag = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.issue_ready    = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic r1, input int t1, input logic r2, input int t2);
        bus.alloc_valid    = 1'b1;
        bus.alloc_src1_rdy = r1;
        bus.alloc_src1_tag = t1[5:0];
        bus.alloc_src2_rdy = r2;
        bus.alloc_src2_tag = t2[5:0];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        bus.alloc_valid = 1'b1;
        #12;
        n_checks++;
        if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alloc_ready got %0b want 0", bus.alloc_ready); end
        n_checks++;
        if (bus.res_st_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %0b want 0", bus.res_st_wr_en); end
        n_checks++;
        if (bus.res_st_wr_addr !== 5'd0) begin n_fail++; $display("FAIL rst_wr_addr got %0d want 0", bus.res_st_wr_addr); end
        n_checks++;
        if (bus.issue_valid !== 1'b0 || bus.issue_addr !== 5'd0) begin
            n_fail++; $display("FAIL rst_issue got v=%0b a=%0d want v=0 a=0", bus.issue_valid, bus.issue_addr);
        end
        n_checks++;
        if (bus.free_count !== 6'd32) begin n_fail++; $display("FAIL rst_free_count got %0d want 32", bus.free_count); end
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill_and_flush();
        for (int k = 0; k < 32; k++) begin
            adv();
            drive_idle();
            set_alloc(1'b1, 0, 1'b1, 0);
            wr_q.push_back(k);
            #1;
            n_checks++;
            if (bus.res_st_wr_en === 1'b1 && wr_q.size() > 0) begin
                int e;
                e = wr_q.pop_front();
                if (bus.res_st_wr_addr !== e[4:0]) begin n_fail++; $display("FAIL fill_wr_addr got %0d want %0d", bus.res_st_wr_addr, e); end
            end else begin
                n_fail++; $display("FAIL fill_wr_en got %0b want 1 at alloc %0d", bus.res_st_wr_en, k);
            end
        end
        adv();
        #1;
        n_checks++;
        if (bus.alloc_ready !== 1'b0 || bus.res_st_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL full_alloc got rdy=%0b wr=%0b want 0 0", bus.alloc_ready, bus.res_st_wr_en);
        end
        n_checks++;
        if (bus.free_count !== 6'd0) begin n_fail++; $display("FAIL full_free_count got %0d want 0", bus.free_count); end
        n_checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_addr !== 5'd0) begin
            n_fail++; $display("FAIL full_issue got v=%0b a=%0d want v=1 a=0", bus.issue_valid, bus.issue_addr);
        end
        adv();
        bus.flush       = 1'b1;
        bus.cdb_valid   = 1'b1;
        bus.cdb_tag     = 6'd1;
        bus.issue_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.res_st_wr_en !== 1'b0 || bus.alloc_ready !== 1'b0 || bus.issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_outputs got wr=%0b rdy=%0b iss=%0b want 0 0 0",
                               bus.res_st_wr_en, bus.alloc_ready, bus.issue_valid);
        end
        adv();
        drive_idle();
        #1;
        n_checks++;
        if (bus.free_count !== 6'd32 || bus.issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_flush got free=%0d iss=%0b want 32 0", bus.free_count, bus.issue_valid);
        end
    endtask

    task automatic test_wakeup();
        adv();
        drive_idle();
        set_alloc(1'b0, 5, 1'b1, 0);
        #1;
        n_checks++;
        if (bus.res_st_wr_en !== 1'b1 || bus.res_st_wr_addr !== 5'd0) begin
            n_fail++; $display("FAIL wake_alloc got wr=%0b a=%0d want 1 0", bus.res_st_wr_en, bus.res_st_wr_addr);
        end
        adv();
        drive_idle();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd4;
        adv();
        drive_idle();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd5;
        #1;
        n_checks++;
        if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_early got %0b want 0", bus.issue_valid); end
        adv();
        drive_idle();
        bus.issue_ready = 1'b1;
        iss_q.push_back(0);
        #1;
        n_checks++;
        if (bus.issue_valid === 1'b1 && iss_q.size() > 0) begin
            int e;
            e = iss_q.pop_front();
            if (bus.issue_addr !== e[4:0]) begin n_fail++; $display("FAIL wake_issue_addr got %0d want %0d", bus.issue_addr, e); end
        end else begin
            n_fail++; $display("FAIL wake_issue_valid got %0b want 1", bus.issue_valid);
        end
        // Two waiters: entry 0 on tag 7, entry 1 on tag 3; tag 3 arrives first.
        adv();
        drive_idle();
        set_alloc(1'b0, 7, 1'b1, 0);
        adv();
        drive_idle();
        set_alloc(1'b1, 0, 1'b0, 3);
        #1;
        n_checks++;
        if (bus.res_st_wr_addr !== 5'd1) begin n_fail++; $display("FAIL wake2_wr_addr got %0d want 1", bus.res_st_wr_addr); end
        adv();
        drive_idle();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd3;
        iss_q.push_back(1);
        iss_q.push_back(0);
        adv();
        drive_idle();
        bus.issue_ready = 1'b1;
        bus.cdb_valid   = 1'b1;
        bus.cdb_tag     = 6'd7;
        for (int c = 0; c < 6 && iss_q.size() > 0; c++) begin
            #1;
            if (bus.issue_valid === 1'b1) begin
                int e;
                e = iss_q.pop_front();
                n_checks++;
                if (bus.issue_addr !== e[4:0]) begin n_fail++; $display("FAIL wake2_issue got %0d want %0d", bus.issue_addr, e); end
            end
            adv();
            bus.cdb_valid = 1'b0;
        end
        n_checks++;
        if (iss_q.size() != 0) begin n_fail++; $display("FAIL wake2_timeout got %0d pending want 0", iss_q.size()); iss_q.delete(); end
        drive_idle();
        #1;
        n_checks++;
        if (bus.free_count !== 6'd32) begin n_fail++; $display("FAIL wake2_free got %0d want 32", bus.free_count); end
    endtask

    task automatic test_bypass();
        adv();
        drive_idle();
        set_alloc(1'b1, 0, 1'b0, 9);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd9;
        adv();
        drive_idle();
        set_alloc(1'b0, 2, 1'b1, 0);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd9;
        #1;
        n_checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_addr !== 5'd0) begin
            n_fail++; $display("FAIL bypass_issue got v=%0b a=%0d want v=1 a=0", bus.issue_valid, bus.issue_addr);
        end
        adv();
        drive_idle();
        bus.issue_ready = 1'b1;
        adv();
        #1;
        n_checks++;
        if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_wait got %0b want 0", bus.issue_valid); end
        n_checks++;
        if (bus.free_count !== 6'd31) begin n_fail++; $display("FAIL bypass_free got %0d want 31", bus.free_count); end
        adv();
        drive_idle();
        bus.flush = 1'b1;
        adv();
        drive_idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            adv();
            drive_idle();
            set_alloc(1'b1, 0, 1'b1, 0);
        end
        wr_q.push_back(2);
        wr_q.push_back(0);
        iss_q.push_back(0);
        iss_q.push_back(1);
        for (int c = 0; c < 2; c++) begin
            adv();
            drive_idle();
            set_alloc(1'b1, 0, 1'b1, 0);
            bus.issue_ready = 1'b1;
            #1;
            n_checks++;
            if (bus.res_st_wr_en === 1'b1 && bus.issue_valid === 1'b1) begin
                int ew;
                int ei;
                ew = wr_q.pop_front();
                ei = iss_q.pop_front();
                if (bus.res_st_wr_addr !== ew[4:0] || bus.issue_addr !== ei[4:0]) begin
                    n_fail++; $display("FAIL b2b_addr got wr=%0d iss=%0d want wr=%0d iss=%0d",
                                       bus.res_st_wr_addr, bus.issue_addr, ew, ei);
                end
            end else begin
                n_fail++; $display("FAIL b2b_strobes got wr=%0b iss=%0b want 1 1", bus.res_st_wr_en, bus.issue_valid);
            end
        end
        iss_q.push_back(0);
        iss_q.push_back(2);
        adv();
        drive_idle();
        bus.issue_ready = 1'b1;
        for (int c = 0; c < 6 && iss_q.size() > 0; c++) begin
            #1;
            if (bus.issue_valid === 1'b1) begin
                int e;
                e = iss_q.pop_front();
                n_checks++;
                if (bus.issue_addr !== e[4:0]) begin n_fail++; $display("FAIL b2b_drain got %0d want %0d", bus.issue_addr, e); end
            end
            adv();
        end
        n_checks++;
        if (iss_q.size() != 0) begin n_fail++; $display("FAIL b2b_timeout got %0d pending want 0", iss_q.size()); iss_q.delete(); end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 10; k++) begin
            adv();
            drive_idle();
            set_alloc(1'b1, 0, 1'b1, 0);
            wr_q.push_back(k);
            #1;
            if (bus.res_st_wr_en === 1'b1) begin
                int e;
                e = wr_q.pop_front();
                n_checks++;
                if (bus.res_st_wr_addr !== e[4:0]) begin n_fail++; $display("FAIL rmid_wr got %0d want %0d", bus.res_st_wr_addr, e); end
            end
        end
        n_checks++;
        if (wr_q.size() != 0) begin n_fail++; $display("FAIL rmid_wr_pending got %0d want 0", wr_q.size()); wr_q.delete(); end
        adv();
        drive_idle();
        #1;
        n_checks++;
        if (bus.free_count !== 6'd22) begin n_fail++; $display("FAIL rmid_free got %0d want 22", bus.free_count); end
        rst = 1'b0;
        bus.issue_ready = 1'b1;
        bus.alloc_valid = 1'b1;
        #1;
        n_checks++;
        if (bus.alloc_ready !== 1'b0 || bus.res_st_wr_en !== 1'b0 || bus.res_st_wr_addr !== 5'd0 ||
            bus.issue_valid !== 1'b0 || bus.issue_addr !== 5'd0 || bus.free_count !== 6'd32) begin
            n_fail++; $display("FAIL rmid_outputs got rdy=%0b wr=%0b wa=%0d iv=%0b ia=%0d fc=%0d want 0 0 0 0 0 32",
                               bus.alloc_ready, bus.res_st_wr_en, bus.res_st_wr_addr,
                               bus.issue_valid, bus.issue_addr, bus.free_count);
        end
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        adv();
        set_alloc(1'b1, 0, 1'b1, 0);
        #1;
        n_checks++;
        if (bus.res_st_wr_en !== 1'b1 || bus.res_st_wr_addr !== 5'd0 || bus.issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL rmid_first_alloc got wr=%0b a=%0d iv=%0b want 1 0 0",
                               bus.res_st_wr_en, bus.res_st_wr_addr, bus.issue_valid);
        end
        adv();
        drive_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill_and_flush();
        test_wakeup();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (wr_q.size() != 0 || iss_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_leftover got wr=%0d iss=%0d want 0 0", wr_q.size(), iss_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/res_st_sched.md
RES_ST_SCHED -- requirements
Module: res_st_sched

Interface
REQ-001 Parameter RES_ST_DEPTH, default 32, number of reservation-station entries; power of two, 4..64.
REQ-002 Parameter TAG_W, default 6, producer tag width carried by the common data bus (CDB).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 alloc_valid  input  1  dispatch requests one entry this cycle.
REQ-006 alloc_ready  output  1  at least one free entry exists and flush is low.
REQ-007 alloc_src1_rdy, alloc_src2_rdy  input  1 each  source operand already available at dispatch.
REQ-008 alloc_src1_tag, alloc_src2_tag  input  TAG_W each  producer tag of a source that is not yet ready.
REQ-009 res_st_wr_en  output  1  write strobe to the reservation-station storage.
REQ-010 res_st_wr_addr  output  res_st_addr_t  entry being written.
REQ-011 cdb_valid  input  1  result broadcast valid; cdb_tag  input  TAG_W  tag of the broadcast result.
REQ-012 issue_valid  output  1  an entry with both sources ready is offered.
REQ-013 issue_addr  output  res_st_addr_t  offered entry; drives the storage read-address port.
REQ-014 issue_ready  input  1  functional unit accepts the offered entry this cycle.
REQ-015 flush  input  1  discard all entries (mispredict or exception).
REQ-016 free_count  output  $clog2(RES_ST_DEPTH+1)  number of free entries.

Function
REQ-017 Per-entry state: valid, src1_rdy, src2_rdy, src1_tag, src2_tag.
REQ-018 alloc_ready, res_st_wr_en, res_st_wr_addr, issue_valid, issue_addr and free_count shall be combinational from the registered state and the current inputs.
REQ-019 res_st_wr_addr = lowest-index entry with valid=0; res_st_wr_en = alloc_valid & alloc_ready.
REQ-020 On alloc, the entry is valid from the next cycle, with ready bits and tags captured from the alloc_* inputs.
REQ-021 Wakeup: each valid entry with srcN_rdy=0 and srcN_tag==cdb_tag while cdb_valid=1 sets srcN_rdy at the next edge.
REQ-022 Alloc/wakeup bypass: if cdb_valid=1 and cdb_tag equals a not-ready alloc tag in the same cycle, that source is stored ready.
REQ-023 Issue select: issue_addr = lowest-index entry with valid & src1_rdy & src2_rdy; issue_valid = such an entry exists and flush is low.
REQ-024 A newly allocated entry is issuable no earlier than the cycle after allocation; a woken entry is issuable no earlier than the cycle after wakeup.
REQ-025 Handshake: issue_valid & issue_ready clears that entry's valid at the next edge; issue_addr has no hold requirement while issue_ready is low.
REQ-026 An entry freed in cycle N is allocatable from cycle N+1, never in cycle N.
REQ-027 Simultaneous alloc and issue are permitted in the same cycle and always target different entries.
REQ-028 Full: all entries valid -> alloc_ready=0 and res_st_wr_en=0; the alloc request is held by dispatch.
REQ-029 Empty: free_count=RES_ST_DEPTH and issue_valid=0.
REQ-030 flush=1 forces alloc_ready=0, res_st_wr_en=0 and issue_valid=0, and clears every valid bit at the next edge; it overrides alloc, wakeup and issue in the same cycle.
REQ-031 free_count = RES_ST_DEPTH minus the population count of the valid bits.

Reset
REQ-032 rst low asynchronously clears all valid and ready bits and all tags.
REQ-033 During reset: alloc_ready=0, res_st_wr_en=0, res_st_wr_addr=0, issue_valid=0, issue_addr=0, free_count=RES_ST_DEPTH.
REQ-034 Reset asserted mid-operation drops all entries without issuing them; the first alloc after release targets entry 0.

Structure
REQ-035 res_st_addr_t, rob_tag_t (TAG_W bits) and RES_ST_DEPTH shall live in qu_common.
REQ-036 A parameterised sub-module prio_enc (lowest-set-bit index plus found flag) shall be instantiated twice: free-entry select and ready-entry select.
REQ-037 No storage of the µop payload shall reside here; the payload lives in the reservation-station storage.

Verification
REQ-038 Reset, then 32 allocs with both sources ready, issue_ready=0 -> wr_addr 0..31 in order, alloc_ready=0 after the 32nd, free_count=0.
REQ-039 Alloc entry 0 with src1 tag 5 not ready; cdb_valid with tag 5 two cycles later -> issue_valid=1, issue_addr=0 exactly one cycle after the broadcast.
REQ-040 Alloc with src2 tag 9 while cdb_tag=9 is valid in the same cycle -> entry issuable in the next cycle.
REQ-041 Entries 0 and 1 valid and ready; issue_ready=1 and alloc_valid=1 held -> issue addr 0 then 1; alloc lands in entry 2, then entry 0 only after entry 0 is freed.
REQ-042 Full station, flush pulse with concurrent alloc_valid, cdb_valid and issue_ready -> no write and no issue that cycle; free_count=32 next cycle.
REQ-043 Assert rst with 10 valid entries -> all outputs at reset values immediately; after release the first alloc targets entry 0.
